// File: rtl/dp_decode_stage.sv
// Decode stage between fetch and execute: classifies an ARM instruction, reads up to two
// source registers from the bank (one or two ports) and forms immediate operands.
module dp_decode_stage #(
   parameter int DATA_W       = 32,
   parameter int NUM_RD_PORTS = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [31:0]                      in_instr,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [DATA_W-1:0]                out_op1,
   output logic [DATA_W-1:0]                out_op2,
   output logic [11:0]                      out_op3,
   output logic [31:0]                      out_instr,
   output logic [3:0]                       out_type,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NUM_RD_PORTS-1:0]          rb_req,
   output logic [4*NUM_RD_PORTS-1:0]        rb_addr,
   input  logic [DATA_W*NUM_RD_PORTS-1:0]   rb_rdata,
   input  logic [NUM_RD_PORTS-1:0]          rb_ack,
   input  logic                             rb_busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_A  = 3'd1,
      RD_B  = 3'd2,
      RD_AB = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic [3:0]        kind;
      logic              need_a;
      logic              need_b;
      logic [3:0]        addr_a;
      logic [3:0]        addr_b;
      logic [DATA_W-1:0] imm;
   } dec_t;

   function automatic logic [31:0] ror_imm(input logic [7:0] imm8, input logic [3:0] rot);
      logic [63:0] dbl;
      dbl = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
      return dbl[31:0];
   endfunction

   function automatic dec_t decode(input logic [31:0] ins);
      dec_t        d;
      logic [25:0] boff;
      d    = '0;
      boff = {ins[23:0], 2'b00};
      if (ins[31:28] == 4'hF) begin
         d.kind = 4'd15;
      end else if (ins[27:24] == 4'hF) begin
         d.kind = 4'd5;
      end else if (ins[27:25] == 3'b101) begin
         d.kind = 4'd3;
         d.imm  = DATA_W'($signed(boff));
      end else if (ins[27:25] == 3'b100) begin
         d.kind   = 4'd4;
         d.need_a = 1'b1;
         d.addr_a = ins[19:16];
         d.imm    = DATA_W'(ins[15:0]);
      end else if (ins[27:26] == 2'b01) begin
         d.kind   = 4'd2;
         d.need_a = 1'b1;
         d.addr_a = ins[19:16];
         if (ins[25]) begin
            d.need_b = 1'b1;
            d.addr_b = ins[3:0];
         end else begin
            d.imm = DATA_W'(ins[11:0]);
         end
      end else if (ins[27:22] == 6'b000000 && ins[7:4] == 4'b1001) begin
         d.kind   = 4'd1;
         d.need_a = 1'b1;
         d.addr_a = ins[3:0];
         d.need_b = 1'b1;
         d.addr_b = ins[11:8];
      end else if (ins[27:26] == 2'b00 && (ins[25] || !ins[7] || !ins[4])) begin
         d.kind   = 4'd0;
         // MOV and MVN have no first operand
         d.need_a = !(ins[24:21] == 4'b1101 || ins[24:21] == 4'b1111);
         d.addr_a = ins[19:16];
         if (ins[25]) begin
            d.imm = DATA_W'(ror_imm(ins[7:0], ins[11:8]));
         end else begin
            d.need_b = 1'b1;
            d.addr_b = ins[3:0];
         end
      end else begin
         d.kind = 4'd15;
      end
      return d;
   endfunction

   state_t            state_r;
   logic [31:0]       instr_r;
   logic              cap_a_r;
   logic              cap_b_r;
   logic [31:0]       dec_src_s;
   dec_t              dec_s;
   logic              req0_s;
   logic [3:0]        addr0_s;
   logic              ack0_s;
   logic              hit_a_s;
   logic              hit_b_s;
   logic              hit_b1_s;
   logic              done_ab_s;
   logic [DATA_W-1:0] rdata0_s;
   logic [DATA_W-1:0] rdata1_s;

   assign dec_src_s = (state_r == IDLE) ? in_instr : instr_r;
   assign dec_s     = decode(dec_src_s);
   assign in_ready  = (state_r == IDLE) && rst_n;
   assign ack0_s    = rb_ack[0];
   assign rdata0_s  = rb_rdata[DATA_W-1:0];

   // Port 0 request/address: A in RD_A and RD_AB, B in RD_B
   always_comb begin
      req0_s  = 1'b0;
      addr0_s = 4'd0;
      case (state_r)
         RD_A: begin
            addr0_s = dec_s.addr_a;
            req0_s  = !rb_busy && !cap_a_r;
         end
         RD_B: begin
            addr0_s = dec_s.addr_b;
            req0_s  = !rb_busy && !cap_b_r;
         end
         RD_AB: begin
            addr0_s = dec_s.addr_a;
            req0_s  = dec_s.need_a && !rb_busy && !cap_a_r;
         end
         default: begin
            addr0_s = 4'd0;
            req0_s  = 1'b0;
         end
      endcase
   end

   // Which read completes this cycle, and whether the parallel read set is complete
   always_comb begin
      hit_a_s = 1'b0;
      hit_b_s = hit_b1_s;
      if (req0_s && ack0_s) begin
         if (state_r == RD_B) begin
            hit_b_s = 1'b1;
         end else begin
            hit_a_s = 1'b1;
         end
      end else begin
         hit_a_s = 1'b0;
      end
      done_ab_s = (cap_a_r || hit_a_s || !dec_s.need_a) &&
                  (cap_b_r || hit_b_s || !dec_s.need_b);
   end

   generate
      if (NUM_RD_PORTS == 2) begin : g_two_port
         logic       req1_s;
         logic [3:0] addr1_s;

         // Port 1 only ever serves B, and only in RD_AB
         always_comb begin
            addr1_s = dec_s.addr_b;
            if (state_r == RD_AB && dec_s.need_b && !cap_b_r && !rb_busy) begin
               req1_s = 1'b1;
            end else begin
               req1_s = 1'b0;
            end
         end

         assign hit_b1_s = req1_s & rb_ack[1];
         assign rdata1_s = rb_rdata[2*DATA_W-1:DATA_W];
         assign rb_req   = {req1_s, req0_s};
         assign rb_addr  = {addr1_s, addr0_s};
      end else begin : g_one_port
         assign hit_b1_s = 1'b0;
         assign rdata1_s = '0;
         assign rb_req   = req0_s;
         assign rb_addr  = addr0_s;
      end
   endgenerate

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         instr_r   <= 32'd0;
         cap_a_r   <= 1'b0;
         cap_b_r   <= 1'b0;
         out_op1   <= '0;
         out_op2   <= '0;
         out_op3   <= 12'd0;
         out_instr <= 32'd0;
         out_type  <= 4'd0;
         out_valid <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  instr_r   <= in_instr;
                  out_instr <= in_instr;
                  out_type  <= dec_s.kind;
                  out_op3   <= in_instr[11:0];
                  out_op1   <= '0;
                  out_op2   <= dec_s.imm;
                  cap_a_r   <= 1'b0;
                  cap_b_r   <= 1'b0;
                  if (dec_s.need_a || dec_s.need_b) begin
                     out_valid <= 1'b0;
                     if (NUM_RD_PORTS == 2) begin
                        state_r <= RD_AB;
                     end else if (dec_s.need_a) begin
                        state_r <= RD_A;
                     end else begin
                        state_r <= RD_B;
                     end
                  end else begin
                     state_r   <= DONE;
                     out_valid <= 1'b1;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_A: begin
               if (hit_a_s) begin
                  out_op1 <= rdata0_s;
                  cap_a_r <= 1'b1;
                  if (dec_s.need_b) begin
                     state_r <= RD_B;
                  end else begin
                     state_r   <= DONE;
                     out_valid <= 1'b1;
                  end
               end else begin
                  state_r <= RD_A;
               end
            end
            RD_B: begin
               if (hit_b_s) begin
                  out_op2   <= rdata0_s;
                  cap_b_r   <= 1'b1;
                  state_r   <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  state_r <= RD_B;
               end
            end
            RD_AB: begin
               if (hit_a_s) begin
                  out_op1 <= rdata0_s;
                  cap_a_r <= 1'b1;
               end else begin
                  cap_a_r <= cap_a_r;
               end
               if (hit_b1_s) begin
                  out_op2 <= rdata1_s;
                  cap_b_r <= 1'b1;
               end else begin
                  cap_b_r <= cap_b_r;
               end
               if (done_ab_s) begin
                  state_r   <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  state_r <= RD_AB;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dp_decode_stage.sv
// Directed bench for dp_decode_stage: one-port and two-port instances, a bank responder
// with programmable busy/wait cycles, and a scoreboard of expected decode results.
module tb_dp_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_instr;
   logic        in_valid1, in_valid2, out_ready;
   logic        rb_busy;

   logic        a_in_ready, a_valid;
   logic [31:0] a_op1, a_op2, a_instr;
   logic [11:0] a_op3;
   logic [3:0]  a_type;
   logic [0:0]  a_req, a_ack;
   logic [3:0]  a_addr;
   logic [31:0] a_rdata;

   logic        b_in_ready, b_valid;
   logic [31:0] b_op1, b_op2, b_instr;
   logic [11:0] b_op3;
   logic [3:0]  b_type;
   logic [1:0]  b_req, b_ack;
   logic [7:0]  b_addr;
   logic [63:0] b_rdata;

   logic        sel, arm, force_ack, ack_en;
   int          cyc, busy_len, wait_len;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [11:0] op3;
      logic [31:0] instr;
      logic [3:0]  kind;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   logic        req_log [0:15];
   logic [3:0]  addr_log [0:15];
   logic        req1_log [0:15];
   logic [3:0]  addr1_log [0:15];

   always #5 clk = ~clk;

   dp_decode_stage #(.DATA_W(32), .NUM_RD_PORTS(1)) u_one (
      .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid1), .in_ready(a_in_ready),
      .out_op1(a_op1), .out_op2(a_op2), .out_op3(a_op3), .out_instr(a_instr), .out_type(a_type),
      .out_valid(a_valid), .out_ready(out_ready), .rb_req(a_req), .rb_addr(a_addr),
      .rb_rdata(a_rdata), .rb_ack(a_ack), .rb_busy(rb_busy)
   );

   dp_decode_stage #(.DATA_W(32), .NUM_RD_PORTS(2)) u_two (
      .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid2), .in_ready(b_in_ready),
      .out_op1(b_op1), .out_op2(b_op2), .out_op3(b_op3), .out_instr(b_instr), .out_type(b_type),
      .out_valid(b_valid), .out_ready(out_ready), .rb_req(b_req), .rb_addr(b_addr),
      .rb_rdata(b_rdata), .rb_ack(b_ack), .rb_busy(rb_busy)
   );

   function automatic logic [31:0] bank_val(input logic [3:0] a);
      return (a == 4'd2) ? 32'h0000_0011 : (32'hA5A5_0000 | {28'd0, a});
   endfunction

   // Bank responder: busy for busy_len cycles after accept, then ack held off for wait_len
   assign rb_busy = arm && (cyc < busy_len);
   assign ack_en  = !arm || (cyc >= busy_len + wait_len);
   assign a_ack   = (a_req & {ack_en}) | {force_ack};
   assign b_ack   = (b_req & {2{ack_en}}) | {2{force_ack}};
   assign a_rdata = bank_val(a_addr);
   assign b_rdata = {bank_val(b_addr[7:4]), bank_val(b_addr[3:0])};

   always @(posedge clk) begin
      if (!arm) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   logic        s_valid, s_ready, s_req0, s_req1;
   logic [31:0] s_op1, s_op2, s_instr;
   logic [11:0] s_op3;
   logic [3:0]  s_type, s_addr0, s_addr1;
   assign s_valid = sel ? b_valid : a_valid;
   assign s_ready = sel ? b_in_ready : a_in_ready;
   assign s_op1   = sel ? b_op1 : a_op1;
   assign s_op2   = sel ? b_op2 : a_op2;
   assign s_op3   = sel ? b_op3 : a_op3;
   assign s_instr = sel ? b_instr : a_instr;
   assign s_type  = sel ? b_type : a_type;
   assign s_req0  = sel ? b_req[0] : a_req[0];
   assign s_addr0 = sel ? b_addr[3:0] : a_addr;
   assign s_req1  = sel ? b_req[1] : 1'b0;
   assign s_addr1 = sel ? b_addr[7:4] : 4'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2, input logic [11:0] op3,
                               input logic [31:0] ins, input logic [3:0] kind, input int lat);
      exp_t e;
      e.op1 = op1; e.op2 = op2; e.op3 = op3; e.instr = ins; e.kind = kind; e.lat = lat;
      return e;
   endfunction

   // Issue one instruction to the selected DUT, wait for its result, compare, then handshake
   task automatic run(input logic which, input logic [31:0] ins, input exp_t e, input int hold);
      exp_t got;
      int   lat;
      bit   seen;
      lat  = 0;
      seen = 1'b0;
      sel  = which;
      @(negedge clk);
      chk("in_ready_before_accept", 32'(s_ready), 32'd1);
      in_instr = ins;
      if (which) in_valid2 = 1'b1;
      else       in_valid1 = 1'b1;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
      arm       = 1'b1;
      for (int k = 0; k < 16; k++) begin
         req_log[k] = 1'b0; addr_log[k] = 4'd0; req1_log[k] = 1'b0; addr1_log[k] = 4'd0;
      end
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         if (k < 16) begin
            req_log[k] = s_req0; addr_log[k] = s_addr0;
            req1_log[k] = s_req1; addr1_log[k] = s_addr1;
         end
         if (s_valid) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      got = sbq.pop_front();
      chk("latency", 32'(lat), 32'(got.lat));
      chk("op1", s_op1, got.op1);
      chk("op2", s_op2, got.op2);
      chk("op3", 32'(s_op3), 32'(got.op3));
      chk("instr", s_instr, got.instr);
      chk("type", 32'(s_type), 32'(got.kind));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(s_valid), 32'd1);
         chk("hold_in_ready", 32'(s_ready), 32'd0);
         chk("hold_op2", s_op2, got.op2);
         chk("hold_instr", s_instr, got.instr);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      arm       = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_instr = 32'd0; in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
      sel = 1'b0; arm = 1'b0; force_ack = 1'b0; busy_len = 0; wait_len = 0;
      #12;
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_op1", a_op1, 32'd0);
      chk("rst_op2", a_op2, 32'd0);
      chk("rst_op3", 32'(a_op3), 32'd0);
      chk("rst_instr", a_instr, 32'd0);
      chk("rst_type", 32'(a_type), 32'd0);
      chk("rst_req", 32'(a_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);

      // ADD R1,R2,#0x3F000000: one read, rotated immediate
      run(1'b0, 32'hE282_143F, mk(32'h11, 32'h3F00_0000, 12'h43F, 32'hE282_143F, 4'd0, 2), 0);
      chk("add_addr", 32'(addr_log[1]), 32'd2);

      // SUB R3,R4,R5 on one port: sequential reads of R4 then R5
      run(1'b0, 32'hE044_3005, mk(bank_val(4'd4), bank_val(4'd5), 12'h005, 32'hE044_3005, 4'd0, 3), 0);
      chk("sub1_req_c1", 32'(req_log[1]), 32'd1);
      chk("sub1_addr_c1", 32'(addr_log[1]), 32'd4);
      chk("sub1_req_c2", 32'(req_log[2]), 32'd1);
      chk("sub1_addr_c2", 32'(addr_log[2]), 32'd5);

      // Same SUB on two ports: both reads in one cycle
      run(1'b1, 32'hE044_3005, mk(bank_val(4'd4), bank_val(4'd5), 12'h005, 32'hE044_3005, 4'd0, 2), 0);
      chk("sub2_req0", 32'(req_log[1]), 32'd1);
      chk("sub2_addr0", 32'(addr_log[1]), 32'd4);
      chk("sub2_req1", 32'(req1_log[1]), 32'd1);
      chk("sub2_addr1", 32'(addr1_log[1]), 32'd5);

      // MUL R0,R1,R2 on two ports: A=Rm, B=Rs
      run(1'b1, 32'hE000_0291, mk(bank_val(4'd1), 32'h11, 12'h291, 32'hE000_0291, 4'd1, 2), 0);

      // MOV R0,#1, rotate-by-1 immediate, branches: no reads
      run(1'b0, 32'hE3A0_0001, mk(32'd0, 32'd1, 12'h001, 32'hE3A0_0001, 4'd0, 1), 0);
      chk("mov_no_req", 32'(req_log[1]), 32'd0);
      run(1'b0, 32'hE3A0_01FF, mk(32'd0, 32'hC000_003F, 12'h1FF, 32'hE3A0_01FF, 4'd0, 1), 0);
      run(1'b0, 32'hEA00_0002, mk(32'd0, 32'd8, 12'h002, 32'hEA00_0002, 4'd3, 1), 0);
      run(1'b0, 32'hEAFF_FFFE, mk(32'd0, 32'hFFFF_FFF8, 12'hFFE, 32'hEAFF_FFFE, 4'd3, 1), 0);

      // Load immediate offset, block transfer, SWI
      run(1'b0, 32'hE591_0004, mk(bank_val(4'd1), 32'd4, 12'h004, 32'hE591_0004, 4'd2, 2), 0);
      run(1'b0, 32'hE92D_4010, mk(bank_val(4'd13), 32'h4010, 12'h010, 32'hE92D_4010, 4'd4, 2), 0);
      run(1'b0, 32'hEF00_0000, mk(32'd0, 32'd0, 12'h000, 32'hEF00_0000, 4'd5, 1), 0);

      // Semaphore held 4 cycles then ack delayed 2
      busy_len = 4;
      wait_len = 2;
      run(1'b0, 32'hE282_143F, mk(32'h11, 32'h3F00_0000, 12'h43F, 32'hE282_143F, 4'd0, 8), 0);
      chk("busy_req_c2", 32'(req_log[2]), 32'd0);
      chk("busy_req_c4", 32'(req_log[4]), 32'd0);
      chk("busy_req_c5", 32'(req_log[5]), 32'd1);
      busy_len = 0;
      wait_len = 0;

      // Downstream stall for 5 cycles, then back-to-back accept
      run(1'b0, 32'hE044_3005, mk(bank_val(4'd4), bank_val(4'd5), 12'h005, 32'hE044_3005, 4'd0, 3), 5);
      run(1'b0, 32'hE3A0_0001, mk(32'd0, 32'd1, 12'h001, 32'hE3A0_0001, 4'd0, 1), 0);

      // Reset in the middle of a read, then a stale ack
      sel = 1'b0;
      wait_len = 100;
      @(negedge clk);
      in_instr  = 32'hE282_143F;
      in_valid1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      arm       = 1'b1;
      @(negedge clk);
      chk("mid_read_req", 32'(a_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_drops_req", 32'(a_req), 32'd0);
      chk("rst_drops_valid", 32'(a_valid), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      arm       = 1'b0;
      wait_len  = 0;
      force_ack = 1'b1;
      repeat (2) @(negedge clk);
      chk("stale_in_ready", 32'(a_in_ready), 32'd1);
      chk("stale_valid", 32'(a_valid), 32'd0);
      chk("stale_op1", a_op1, 32'd0);
      chk("stale_req", 32'(a_req), 32'd0);
      force_ack = 1'b0;

      // Unconditional-never and coprocessor encodings
      run(1'b0, 32'hF282_143F, mk(32'd0, 32'd0, 12'h43F, 32'hF282_143F, 4'd15, 1), 0);
      chk("cond_f_no_req", 32'(req_log[1]), 32'd0);
      run(1'b1, 32'hEE00_0000, mk(32'd0, 32'd0, 12'h000, 32'hEE00_0000, 4'd15, 1), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
